// File: rtl/fp_clock_ctrl_if.sv
// fp_clock_ctrl_if: front-panel bundle between the panel/CPU side and the clock controller
interface fp_clock_ctrl_if #(
  parameter int N_BTN   = 8,
  parameter int BURST_W = 8
);
  logic [N_BTN-1:0]   btn_raw;
  logic [1:0]         mode;
  logic [BURST_W-1:0] burst_len;
  logic               hlt;
  logic               tick;
  logic [N_BTN-1:0]   btn_level;
  logic [N_BTN-1:0]   btn_rise;
  logic               cpu_ce;
  logic               busy;
  modport master (output btn_raw, mode, burst_len, hlt, input tick, btn_level, btn_rise, cpu_ce, busy);
  modport slave  (input btn_raw, mode, burst_len, hlt, output tick, btn_level, btn_rise, cpu_ce, busy);
endinterface

// File: rtl/fp_clock_ctrl.sv
// fp_clock_ctrl: panel debounce and single-cycle CPU clock-enable (run/step/burst/hold); FP_BURST_EN enables burst mode
module fp_clock_ctrl #(
  parameter int N_BTN     = 8,
  parameter int DIV       = 100000,
  parameter int DEB_TICKS = 4,
  parameter int STEP_IDX  = 0,
  parameter int BURST_W   = 8
) (
  input logic            clk,
  input logic            clr_n,
  fp_clock_ctrl_if.slave fp
);
  localparam int CW = $clog2(DIV);
  localparam int DW = $clog2(DEB_TICKS + 1);
  logic [CW-1:0]    div_cnt;
  logic [DW-1:0]    deb_cnt [N_BTN];
  logic [N_BTN-1:0] meta, sync, level, level_q;
  logic [1:0]       mode_q;
  logic             tick, ce, ce_n, step, abort, brst;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      div_cnt <= '0;
      tick    <= 1'b0;
      meta    <= '0;
      sync    <= '0;
      level   <= '0;
      level_q <= '0;
      mode_q  <= '0;
      ce      <= 1'b0;
      for (int i = 0; i < N_BTN; i++) deb_cnt[i] <= '0;
    end else begin
      div_cnt <= (div_cnt == CW'(DIV - 1)) ? '0 : div_cnt + 1'b1;
      tick    <= div_cnt == CW'(DIV - 2);
      meta    <= fp.btn_raw;
      sync    <= meta;
      level_q <= level;
      mode_q  <= fp.mode;
      ce      <= ce_n;
      // any cycle where the input agrees with the held level discards partial evidence
      for (int i = 0; i < N_BTN; i++)
        if (sync[i] == level[i]) deb_cnt[i] <= '0;
        else if (tick && deb_cnt[i] == DW'(DEB_TICKS - 1)) begin
          level[i]   <= sync[i];
          deb_cnt[i] <= '0;
        end else if (tick) deb_cnt[i] <= deb_cnt[i] + 1'b1;
    end
  assign step  = level[STEP_IDX] & ~level_q[STEP_IDX];
  assign abort = fp.hlt | (fp.mode != mode_q);
  always_comb
    ce_n = !abort && (fp.mode == 2'b00 ? tick : fp.mode == 2'b01 ? step : fp.mode == 2'b10 ? brst : 1'b0);
`ifdef FP_BURST_EN
  typedef enum logic {IDLE, BURST} state_t;
  state_t             state, state_n;
  logic [BURST_W-1:0] bcnt, bcnt_n;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      state <= IDLE;
      bcnt  <= '0;
    end else begin
      state <= state_n;
      bcnt  <= bcnt_n;
    end
  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    if (abort || fp.mode != 2'b10) begin
      state_n = IDLE;
      bcnt_n  = '0;
    end else if (state == IDLE) begin
      if (step && fp.burst_len != '0) begin
        state_n = BURST;
        bcnt_n  = fp.burst_len;
      end
    end else if (tick) begin
      bcnt_n  = bcnt - 1'b1;
      state_n = (bcnt == BURST_W'(1)) ? IDLE : BURST;
    end
  end
  assign brst    = (state == BURST) & tick;
  assign fp.busy = state == BURST;
`else
  logic unused_burst_len;
  assign unused_burst_len = ^fp.burst_len;
  assign brst             = step;
  assign fp.busy          = 1'b0;
`endif
  assign fp.tick      = tick;
  assign fp.btn_level = level;
  assign fp.btn_rise  = level & ~level_q;
  assign fp.cpu_ce    = ce;
endmodule

// File: tb/tb_fp_clock_ctrl.sv
// tb_fp_clock_ctrl: scoreboard bench for fp_clock_ctrl with DIV=4, DEB_TICKS=3, N_BTN=4
module tb_fp_clock_ctrl;
  localparam int NB = 4;
  localparam int BW = 8;
  logic clk = 1'b0;
  logic clr_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   dbl = 0;
  int   exp_q[$];
  logic ce_prev = 1'b0;
  always #5 clk = ~clk;
  fp_clock_ctrl_if #(.N_BTN(NB), .BURST_W(BW)) fp();
  fp_clock_ctrl #(.N_BTN(NB), .DIV(4), .DEB_TICKS(3), .STEP_IDX(0), .BURST_W(BW)) dut (
    .clk(clk),
    .clr_n(clr_n),
    .fp(fp)
  );
  always @(negedge clk) begin
    if (fp.cpu_ce && ce_prev) dbl++;
    ce_prev = fp.cpu_ce;
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic run(input int n, output int c, output int orphan);
    logic pt;
    pt = fp.tick;
    c = 0;
    orphan = 0;
    repeat (n) begin
      @(negedge clk);
      if (fp.cpu_ce) begin
        c++;
        if (!pt) orphan++;
      end
      pt = fp.tick;
    end
  endtask
  task automatic press(output int c);
    int c1, c2, o;
    fp.btn_raw[0] = 1'b1;
    run(25, c1, o);
    fp.btn_raw[0] = 1'b0;
    run(25, c2, o);
    c = c1 + c2;
  endtask
  task automatic burst_seq(input bit twice, output int c, output int b_after, output int b_last,
                           output int b_pre, output int b_r2, output int bmax);
    int   r1 = -1;
    int   nr = 0;
    logic pb = 1'b0;
    c = 0; b_after = 0; b_last = -1; b_pre = -1; b_r2 = -1; bmax = 0;
    fp.btn_raw[0] = 1'b1;
    for (int j = 0; j < 130; j++) begin
      @(negedge clk);
      if (fp.btn_rise[0]) begin
        nr++;
        if (nr == 1) r1 = j;
        if (nr == 2) b_r2 = fp.busy;
      end
      if (r1 >= 0 && j == r1 + 1) b_after = fp.busy;
      if (fp.cpu_ce) begin
        c++;
        b_last = fp.busy;
        b_pre  = pb;
      end
      if (fp.busy) bmax = 1;
      pb = fp.busy;
      fp.btn_raw[0] = (j < 19) || (twice && j >= 39 && j < 59);
    end
  endtask
  initial begin
    int   c, o, seen, nt, j3, ba, bl, bp, br2, bm, jh;
    logic lv [32];
    logic rs [32];
    fp.btn_raw = '0; fp.mode = 2'b11; fp.burst_len = '0; fp.hlt = 1'b0;
    @(negedge clk);
    repeat (2) @(negedge clk);
    chk("rst_tick", fp.tick, 0);
    chk("rst_ce", fp.cpu_ce, 0);
    chk("rst_busy", fp.busy, 0);
    chk("rst_level", fp.btn_level, 0);
    chk("rst_rise", fp.btn_rise, 0);
    clr_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("tick_%0d", k), fp.tick, int'(k % 4 == 3));
    end
    // short bounce on button 1 must not move the level
    seen = 0;
    fp.btn_raw[1] = 1'b1;
    repeat (6) begin @(negedge clk); seen |= fp.btn_level[1]; end
    fp.btn_raw[1] = 1'b0;
    repeat (20) begin @(negedge clk); seen |= fp.btn_level[1]; end
    chk("bounce_level", seen, 0);
    fp.btn_raw[1] = 1'b1;
    nt = 0; j3 = -1;
    for (int j = 1; j < 32; j++) begin
      @(negedge clk);
      lv[j] = fp.btn_level[1];
      rs[j] = fp.btn_rise[1];
      if (j >= 2 && fp.tick && nt < 3) begin
        nt++;
        if (nt == 3) j3 = j;
      end
    end
    chk("deb_window", int'(j3 > 0 && j3 < 30), 1);
    if (j3 > 0 && j3 < 30) begin
      chk("deb_level_pre", lv[j3], 0);
      chk("deb_level_post", lv[j3+1], 1);
      chk("deb_rise", rs[j3+1], 1);
      chk("deb_rise_width", rs[j3+2], 0);
    end
    fp.mode = 2'b00;
    repeat (4) @(negedge clk);
    exp_q.push_back(10);
    run(40, c, o);
    chk("run_ce", c, exp_q.pop_front());
    chk("run_ce_after_tick", o, 0);
    fp.hlt = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back(0);
    run(40, c, o);
    chk("run_hlt", c, exp_q.pop_front());
    fp.hlt = 1'b0;
    fp.mode = 2'b01;
    repeat (2) @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      exp_q.push_back(1);
      press(c);
      chk($sformatf("step_press_%0d", p), c, exp_q.pop_front());
    end
    fp.hlt = 1'b1;
    exp_q.push_back(0);
    press(c);
    chk("step_hlt", c, exp_q.pop_front());
    fp.hlt = 1'b0;
    fp.mode = 2'b10;
    fp.burst_len = 8'd5;
    repeat (2) @(negedge clk);
`ifdef FP_BURST_EN
    exp_q.push_back(5);
    burst_seq(1'b0, c, ba, bl, bp, br2, bm);
    chk("burst5_ce", c, exp_q.pop_front());
    chk("burst5_busy_rise1", ba, 1);
    chk("burst5_busy_last", bl, 0);
    chk("burst5_busy_pre_last", bp, 1);
    fp.burst_len = 8'd20;
    exp_q.push_back(20);
    burst_seq(1'b1, c, ba, bl, bp, br2, bm);
    chk("burst20_ce", c, exp_q.pop_front());
    chk("burst20_press2_busy", br2, 1);
    fp.burst_len = 8'd0;
    exp_q.push_back(0);
    burst_seq(1'b0, c, ba, bl, bp, br2, bm);
    chk("burst0_ce", c, exp_q.pop_front());
    chk("burst0_busy", bm, 0);
    // abort: hlt after the second pulse
    fp.burst_len = 8'd5;
    exp_q.push_back(2);
    fp.btn_raw[0] = 1'b1;
    c = 0; jh = -10; ba = -1;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (j == jh + 1) ba = fp.busy;
      if (fp.cpu_ce) c++;
      if (c == 2 && jh < 0) begin fp.hlt = 1'b1; jh = j; end
      if (j == 19) fp.btn_raw[0] = 1'b0;
    end
    chk("abort_ce", c, exp_q.pop_front());
    chk("abort_busy", ba, 0);
    fp.hlt = 1'b0;
    repeat (25) @(negedge clk);
    fp.burst_len = 8'd100;
    fp.btn_raw[0] = 1'b1;
    for (int j = 0; j < 40 && !fp.busy; j++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", fp.busy, 1);
`else
    exp_q.push_back(1);
    burst_seq(1'b0, c, ba, bl, bp, br2, bm);
    chk("mode10_as_step", c, exp_q.pop_front());
    chk("mode10_busy", bm, 0);
    fp.mode = 2'b00;
    repeat (6) @(negedge clk);
`endif
    chk("pre_reset_level1", fp.btn_level[1], 1);
    #2 clr_n = 1'b0;
    #1;
    chk("async_tick", fp.tick, 0);
    chk("async_ce", fp.cpu_ce, 0);
    chk("async_busy", fp.busy, 0);
    chk("async_level", fp.btn_level, 0);
    chk("async_rise", fp.btn_rise, 0);
    @(negedge clk);
    fp.mode = 2'b00;
    clr_n = 1'b1;
    exp_q.push_back(0);
    run(3, c, o);
    chk("post_reset_quiet", c, exp_q.pop_front());
    exp_q.push_back(2);
    run(5, c, o);
    chk("post_reset_run", c, exp_q.pop_front());
    chk("ce_double", dbl, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
